cpu_control_fsm_p: RTL and testbench

- Parametrised successor to the multi-cycle CPU control FSM.
- Decodes 16-bit CR16-style instructions and drives register-file, ALU, RAM and PC control for the datapath.
- Supports the full ISA subset: ALU reg/imm, shifts, MOVI/LUI, LOAD/STOR, Scond, Bcond, Jcond, JAL.
- Memory access is either a Mem_ready handshake or a fixed latency; register-file size is configurable.

---
 rtl/cpu_control_fsm_p_pkg.sv | 153 +++++++++++++++
 rtl/cpu_control_fsm_p_cond_eval.sv | 32 +++
 rtl/cpu_control_fsm_p.sv | 175 +++++++++++++++++
 tb/tb_cpu_control_fsm_p.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_fsm_p_pkg.sv
// Shared encodings for the CR16-style multi-cycle control FSM: opcodes, ALU codes,
// datapath selects, state enum and the instruction decode helper.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_MULI  = 4'b1110;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  // Register-form ext codes reuse the immediate opcode values; 1111 is NOT in register form.
  localparam logic [3:0] EXT_NOT   = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_SCOND = 4'b1101;

  localparam logic [3:0] EXT_LSHI  = 4'b0000;
  localparam logic [3:0] EXT_RSHI  = 4'b0001;
  localparam logic [3:0] EXT_ARSHI = 4'b0010;
  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_RSH   = 4'b0101;
  localparam logic [3:0] EXT_ARSH  = 4'b0110;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_CMP  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOT  = 4'd6;
  localparam logic [3:0] ALU_LSH  = 4'd7;
  localparam logic [3:0] ALU_RSH  = 4'd8;
  localparam logic [3:0] ALU_ARSH = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_MOV  = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;

  localparam logic [1:0] LIS_ALU   = 2'b00;
  localparam logic [1:0] LIS_RAM   = 2'b01;
  localparam logic [1:0] LIS_SCOND = 2'b10;
  localparam logic [1:0] LIS_LINK  = 2'b11;

  localparam logic [1:0] PCS_INC  = 2'b00;
  localparam logic [1:0] PCS_DISP = 2'b01;
  localparam logic [1:0] PCS_REG  = 2'b10;
  localparam logic [1:0] PCS_HOLD = 2'b11;

  localparam int unsigned FLAG_N = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_MEMWAIT, S_LOADWB, S_BRANCH, S_PCUPD
  } state_t;

  typedef enum logic [2:0] {
    K_NOP, K_ALU, K_LOAD, K_STOR, K_SCOND, K_BCOND, K_JCOND, K_JAL
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [3:0] alu_op;
    logic       imm_s;
    logic       sgn;
    logic       wr;
    logic       shift_imm;
  } dec_t;

  typedef struct packed {
    logic       imm_s;
    logic       reg_en;
    logic       ram_en;
    logic       pc_en;
    logic       sgn;
    logic       ram_addr_sel;
    logic [1:0] load_in_sel;
    logic [1:0] pc_state;
    logic [3:0] alu_op;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                LIS_ALU, PCS_HOLD, ALU_ADD};

  function automatic dec_t decode(input logic [3:0] op, input logic [3:0] ext);
    dec_t       d;
    logic [3:0] code;
    d      = '0;
    d.kind = K_NOP;
    code   = (op == OP_REG) ? ext : op;
    case (op)
      OP_REG, OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_ADDUI,
      OP_SUBI, OP_CMPI, OP_MOVI, OP_MULI, OP_LUI: begin
        d.kind  = K_ALU;
        d.wr    = 1'b1;
        d.imm_s = (op != OP_REG);
        case (code)
          OP_ANDI:  d.alu_op = ALU_AND;
          OP_ORI:   d.alu_op = ALU_OR;
          OP_XORI:  d.alu_op = ALU_XOR;
          OP_ADDI:  begin d.alu_op = ALU_ADD; d.sgn = 1'b1; end
          OP_ADDUI: d.alu_op = ALU_ADD;
          OP_SUBI:  begin d.alu_op = ALU_SUB; d.sgn = 1'b1; end
          OP_CMPI:  begin d.alu_op = ALU_CMP; d.sgn = 1'b1; d.wr = 1'b0; end
          OP_MOVI:  d.alu_op = ALU_MOV;
          OP_MULI:  begin d.alu_op = ALU_MUL; d.sgn = 1'b1; end
          EXT_NOT:  d.alu_op = (op == OP_REG) ? ALU_NOT : ALU_LUI;
          default:  begin d.kind = K_NOP; d.wr = 1'b0; d.imm_s = 1'b0; end
        endcase
      end
      OP_SHIFT: begin
        d.kind = K_ALU;
        d.wr   = 1'b1;
        case (ext)
          EXT_LSH:   d.alu_op = ALU_LSH;
          EXT_RSH:   d.alu_op = ALU_RSH;
          EXT_ARSH:  d.alu_op = ALU_ARSH;
          EXT_LSHI:  begin d.alu_op = ALU_LSH;  d.imm_s = 1'b1; d.shift_imm = 1'b1; end
          EXT_RSHI:  begin d.alu_op = ALU_RSH;  d.imm_s = 1'b1; d.shift_imm = 1'b1; end
          EXT_ARSHI: begin d.alu_op = ALU_ARSH; d.imm_s = 1'b1; d.shift_imm = 1'b1; end
          default:   begin d.kind = K_NOP; d.wr = 1'b0; end
        endcase
      end
      OP_MEM: begin
        case (ext)
          EXT_LOAD:  d.kind = K_LOAD;
          EXT_STOR:  d.kind = K_STOR;
          EXT_SCOND: d.kind = K_SCOND;
          EXT_JCOND: d.kind = K_JCOND;
          EXT_JAL:   d.kind = K_JAL;
          default:   d.kind = K_NOP;
        endcase
      end
      OP_BCOND: d.kind = K_BCOND;
      default:  d.kind = K_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_control_fsm_p_cond_eval.sv
// Combinational condition-code evaluator: 4-bit cond against {N,Z,F,L,C} flags.
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      4'd0:    taken =  flags[FLAG_Z];
      4'd1:    taken = !flags[FLAG_Z];
      4'd2:    taken =  flags[FLAG_C];
      4'd3:    taken = !flags[FLAG_C];
      4'd4:    taken =  flags[FLAG_L];
      4'd5:    taken = !flags[FLAG_L];
      4'd6:    taken =  flags[FLAG_N];
      4'd7:    taken = !flags[FLAG_N];
      4'd8:    taken =  flags[FLAG_F];
      4'd9:    taken = !flags[FLAG_F];
      4'd10:   taken = !(flags[FLAG_L] | flags[FLAG_Z]);
      4'd11:   taken =  flags[FLAG_L] | flags[FLAG_Z];
      4'd12:   taken = !(flags[FLAG_N] | flags[FLAG_Z]);
      4'd13:   taken =  flags[FLAG_N] | flags[FLAG_Z];
      4'd14:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm_p.sv
// Multi-cycle control FSM for a CR16-style 16-bit datapath; all outputs are
// registered Moore outputs decoded from the next state and next instruction latch.
module cpu_control_fsm_p
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W    = 4,
  parameter int unsigned IMM_W         = 8,
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned MEM_LAT       = 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [15:0]           Instr,
  input  logic                  Instr_valid,
  input  logic [4:0]            ALUFlags,
  input  logic                  Mem_ready,
  output logic                  Imm_s,
  output logic                  RegEn,
  output logic                  RAMEn,
  output logic                  PCEn,
  output logic                  Signed,
  output logic                  RamAddrSelect,
  output logic [1:0]            LoadInSelect,
  output logic [1:0]            PCState,
  output logic [3:0]            ALUOpCode,
  output logic [REG_ADDR_W-1:0] RdestRegLoc,
  output logic [REG_ADDR_W-1:0] RsrcRegLoc,
  output logic [IMM_W-1:0]      Imm,
  output logic                  Busy
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t                  state, state_n;
  logic [15:0]             ir, ir_n;
  logic [4:0]              fl, fl_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  dec_t                    dec_n;
  logic                    taken;
  logic                    mem_done;
  logic [7:0]              imm8;
  ctl_t                    ctl_q, ctl_n;
  logic [REG_ADDR_W-1:0]   rdest_q, rdest_n, rsrc_q, rsrc_n;
  logic [IMM_W-1:0]        imm_q, imm_n;
  logic                    busy_q;

  always_comb begin
    ir_n = ir;
    fl_n = fl;
    if (state == S_FETCH && Instr_valid) begin
      ir_n = Instr;
      fl_n = ALUFlags;
    end
  end

  // The latch only changes in FETCH, so dec_n also describes the in-flight instruction.
  assign dec_n = decode(ir_n[15:12], ir_n[7:4]);

  cond_eval u_cond_eval (
    .cond  (ir_n[11:8]),
    .flags (fl_n),
    .taken (taken)
  );

  assign mem_done = (MEM_HANDSHAKE != 0) ? Mem_ready : (cnt == CNT_W'(MEM_LAT - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_FETCH: if (Instr_valid) state_n = S_EXEC;
      S_EXEC: begin
        case (dec_n.kind)
          K_LOAD, K_STOR:         begin state_n = S_MEMWAIT; cnt_n = '0; end
          K_BCOND, K_JCOND, K_JAL: state_n = S_BRANCH;
          default:                 state_n = S_PCUPD;
        endcase
      end
      S_MEMWAIT: begin
        if (mem_done) state_n = (dec_n.kind == K_LOAD) ? S_LOADWB : S_PCUPD;
        else          cnt_n   = cnt + CNT_W'(1);
      end
      S_LOADWB: state_n = S_PCUPD;
      S_BRANCH: state_n = S_FETCH;
      S_PCUPD:  state_n = S_FETCH;
      default:  state_n = S_FETCH;
    endcase
  end

  always_comb begin
    imm8 = dec_n.shift_imm ? {4'b0000, ir_n[3:0]} : ir_n[7:0];
  end

  always_comb begin
    ctl_n   = CTL_IDLE;
    rdest_n = '0;
    rsrc_n  = '0;
    imm_n   = '0;
    if (state_n != S_FETCH) begin
      ctl_n.alu_op = dec_n.alu_op;
      ctl_n.imm_s  = dec_n.imm_s;
      ctl_n.sgn    = dec_n.sgn;
      rdest_n      = REG_ADDR_W'(ir_n[11:8]);
      rsrc_n       = REG_ADDR_W'(ir_n[3:0]);
      imm_n        = dec_n.sgn ? IMM_W'($signed(imm8)) : IMM_W'(imm8);
    end
    case (state_n)
      S_EXEC: begin
        case (dec_n.kind)
          K_ALU:   ctl_n.reg_en = dec_n.wr;
          K_LOAD:  ctl_n.ram_addr_sel = 1'b1;
          K_STOR:  begin ctl_n.ram_addr_sel = 1'b1; ctl_n.ram_en = 1'b1; end
          K_SCOND: begin ctl_n.reg_en = 1'b1; ctl_n.load_in_sel = LIS_SCOND; end
          default: ;
        endcase
      end
      S_MEMWAIT: ctl_n.ram_addr_sel = 1'b1;
      S_LOADWB:  begin ctl_n.reg_en = 1'b1; ctl_n.load_in_sel = LIS_RAM; end
      S_BRANCH: begin
        ctl_n.pc_en = 1'b1;
        case (dec_n.kind)
          K_BCOND: ctl_n.pc_state = taken ? PCS_DISP : PCS_INC;
          K_JCOND: ctl_n.pc_state = taken ? PCS_REG  : PCS_INC;
          K_JAL: begin
            ctl_n.reg_en      = 1'b1;
            ctl_n.load_in_sel = LIS_LINK;
            ctl_n.pc_state    = PCS_REG;
          end
          default: ctl_n.pc_state = PCS_INC;
        endcase
      end
      S_PCUPD: begin ctl_n.pc_en = 1'b1; ctl_n.pc_state = PCS_INC; end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_FETCH;
      ir      <= '0;
      fl      <= '0;
      cnt     <= '0;
      ctl_q   <= CTL_IDLE;
      rdest_q <= '0;
      rsrc_q  <= '0;
      imm_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ir      <= ir_n;
      fl      <= fl_n;
      cnt     <= cnt_n;
      ctl_q   <= ctl_n;
      rdest_q <= rdest_n;
      rsrc_q  <= rsrc_n;
      imm_q   <= imm_n;
      busy_q  <= (state_n != S_FETCH);
    end
  end

  assign Imm_s         = ctl_q.imm_s;
  assign RegEn         = ctl_q.reg_en;
  assign RAMEn         = ctl_q.ram_en;
  assign PCEn          = ctl_q.pc_en;
  assign Signed        = ctl_q.sgn;
  assign RamAddrSelect = ctl_q.ram_addr_sel;
  assign LoadInSelect  = ctl_q.load_in_sel;
  assign PCState       = ctl_q.pc_state;
  assign ALUOpCode     = ctl_q.alu_op;
  assign RdestRegLoc   = rdest_q;
  assign RsrcRegLoc    = rsrc_q;
  assign Imm           = imm_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_cpu_control_fsm_p.sv
// Directed bench for cpu_control_fsm_p: handshake instance plus a fixed-latency
// (MEM_LAT=2) instance for the store path.
module tb_cpu_control_fsm_p;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] Instr = '0;
  logic        Instr_valid = 1'b0;
  logic        valid2 = 1'b0;
  logic [4:0]  ALUFlags = '0;
  logic        Mem_ready = 1'b0;

  logic       Imm_s, RegEn, RAMEn, PCEn, Signed, RamAddrSelect, Busy;
  logic [1:0] LoadInSelect, PCState;
  logic [3:0] ALUOpCode, RdestRegLoc, RsrcRegLoc;
  logic [7:0] Imm;

  logic       Imm_s2, RegEn2, RAMEn2, PCEn2, Signed2, RamAddrSelect2, Busy2;
  logic [1:0] LoadInSelect2, PCState2;
  logic [3:0] ALUOpCode2, RdestRegLoc2, RsrcRegLoc2;
  logic [7:0] Imm2;

  logic [6:0] ctl1, ctl2;
  assign ctl1 = {RegEn, RAMEn, PCEn, LoadInSelect, PCState};
  assign ctl2 = {RegEn2, RAMEn2, PCEn2, LoadInSelect2, PCState2};

  int checks = 0;
  int failures = 0;

  cpu_control_fsm_p #(.REG_ADDR_W(4), .IMM_W(8), .MEM_HANDSHAKE(1), .MEM_LAT(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Instr_valid(Instr_valid),
    .ALUFlags(ALUFlags), .Mem_ready(Mem_ready),
    .Imm_s(Imm_s), .RegEn(RegEn), .RAMEn(RAMEn), .PCEn(PCEn), .Signed(Signed),
    .RamAddrSelect(RamAddrSelect), .LoadInSelect(LoadInSelect), .PCState(PCState),
    .ALUOpCode(ALUOpCode), .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc),
    .Imm(Imm), .Busy(Busy)
  );

  cpu_control_fsm_p #(.REG_ADDR_W(4), .IMM_W(8), .MEM_HANDSHAKE(0), .MEM_LAT(2)) dut_fix (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Instr_valid(valid2),
    .ALUFlags(ALUFlags), .Mem_ready(Mem_ready),
    .Imm_s(Imm_s2), .RegEn(RegEn2), .RAMEn(RAMEn2), .PCEn(PCEn2), .Signed(Signed2),
    .RamAddrSelect(RamAddrSelect2), .LoadInSelect(LoadInSelect2), .PCState(PCState2),
    .ALUOpCode(ALUOpCode2), .RdestRegLoc(RdestRegLoc2), .RsrcRegLoc(RsrcRegLoc2),
    .Imm(Imm2), .Busy(Busy2)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    checks++; if (ctl1 !== 7'b0000011) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl1, 7'b0000011); end
    checks++; if ({Busy, Imm_s, Signed, RamAddrSelect, ALUOpCode, Imm} !== 16'h0000) begin failures++; $display("FAIL reset_misc got=%h exp=0000", {Busy, Imm_s, Signed, RamAddrSelect, ALUOpCode, Imm}); end
    checks++; if ({ctl2, Busy2} !== 8'b00000110) begin failures++; $display("FAIL reset_fix got=%b exp=%b", {ctl2, Busy2}, 8'b00000110); end
    Reset_n = 1'b1;
    tick();
    checks++; if ({ctl1, Busy} !== 8'b00000110) begin failures++; $display("FAIL reset_idle got=%b exp=%b", {ctl1, Busy}, 8'b00000110); end
  endtask

  task automatic test_alu_imm();
    Instr = 16'h53FE; Instr_valid = 1'b1;
    tick();
    Instr_valid = 1'b0;
    checks++; if (ctl1 !== 7'b1000011) begin failures++; $display("FAIL addi_exec_ctl got=%b exp=%b", ctl1, 7'b1000011); end
    checks++; if ({Imm_s, Signed, Busy} !== 3'b111) begin failures++; $display("FAIL addi_exec_sel got=%b exp=111", {Imm_s, Signed, Busy}); end
    checks++; if ({ALUOpCode, RdestRegLoc, Imm} !== 16'h03FE) begin failures++; $display("FAIL addi_exec_fields got=%h exp=03fe", {ALUOpCode, RdestRegLoc, Imm}); end
    tick();
    checks++; if (ctl1 !== 7'b0010000) begin failures++; $display("FAIL addi_pcupd got=%b exp=%b", ctl1, 7'b0010000); end
    tick();
    checks++; if ({ctl1, Busy} !== 8'b00000110) begin failures++; $display("FAIL addi_fetch got=%b exp=%b", {ctl1, Busy}, 8'b00000110); end
  endtask

  task automatic test_load_handshake();
    logic [6:0] exp_seq [7] = '{7'b0000011, 7'b0000011, 7'b0000011, 7'b0000011,
                                7'b1000111, 7'b0010000, 7'b0000011};
    int pc_pulses = 0;
    Instr = 16'h4205; Instr_valid = 1'b1; Mem_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) begin
        Instr_valid = 1'b0;
        checks++; if ({RamAddrSelect, RdestRegLoc, RsrcRegLoc} !== 9'h125) begin failures++; $display("FAIL load_exec_addr got=%h exp=125", {RamAddrSelect, RdestRegLoc, RsrcRegLoc}); end
      end
      if (i == 3) Mem_ready = 1'b1;
      if (i == 4) Mem_ready = 1'b0;
      pc_pulses += int'(PCEn);
      checks++; if (ctl1 !== exp_seq[i]) begin failures++; $display("FAIL load_seq%0d got=%b exp=%b", i, ctl1, exp_seq[i]); end
    end
    checks++; if (pc_pulses != 1) begin failures++; $display("FAIL load_pcen_count got=%0d exp=1", pc_pulses); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL load_busy_end got=%b exp=0", Busy); end
  endtask

  task automatic test_branch();
    logic [3:0] cond_t  [11] = '{4'd0, 4'd0, 4'd3, 4'd4, 4'd10, 4'd10, 4'd13, 4'd14, 4'd15, 4'd9, 4'd12};
    logic [4:0] flags_t [11] = '{5'b01000, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b01000,
                                 5'b10000, 5'b00000, 5'b11111, 5'b00100, 5'b00000};
    logic       take_t  [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [6:0] exp_b;
    for (int i = 0; i < 11; i++) begin
      Instr = {4'hC, cond_t[i], 8'h04}; ALUFlags = flags_t[i]; Instr_valid = 1'b1;
      tick();
      Instr_valid = 1'b0;
      ALUFlags = ~flags_t[i];
      checks++; if (ctl1 !== 7'b0000011) begin failures++; $display("FAIL bcond%0d_exec got=%b exp=%b", i, ctl1, 7'b0000011); end
      tick();
      exp_b = take_t[i] ? 7'b0010001 : 7'b0010000;
      checks++; if (ctl1 !== exp_b) begin failures++; $display("FAIL bcond%0d_branch got=%b exp=%b", i, ctl1, exp_b); end
      tick();
      checks++; if ({ctl1, Busy} !== 8'b00000110) begin failures++; $display("FAIL bcond%0d_fetch got=%b exp=%b", i, {ctl1, Busy}, 8'b00000110); end
    end
    ALUFlags = '0;
  endtask

  task automatic test_jump();
    logic [15:0] ins_t [3] = '{16'h4E86, 16'h4EC7, 16'h4FC7};
    logic [6:0]  exp_t [3] = '{7'b1011110, 7'b0010010, 7'b0010000};
    for (int i = 0; i < 3; i++) begin
      Instr = ins_t[i]; Instr_valid = 1'b1;
      tick();
      Instr_valid = 1'b0;
      checks++; if (ctl1 !== 7'b0000011) begin failures++; $display("FAIL jump%0d_exec got=%b exp=%b", i, ctl1, 7'b0000011); end
      tick();
      checks++; if (ctl1 !== exp_t[i]) begin failures++; $display("FAIL jump%0d_branch got=%b exp=%b", i, ctl1, exp_t[i]); end
      if (i == 0) begin
        checks++; if ({RdestRegLoc, RsrcRegLoc} !== 8'hE6) begin failures++; $display("FAIL jal_regs got=%h exp=e6", {RdestRegLoc, RsrcRegLoc}); end
      end
      tick();
    end
    checks++; if ({ctl1, Busy} !== 8'b00000110) begin failures++; $display("FAIL jump_fetch got=%b exp=%b", {ctl1, Busy}, 8'b00000110); end
  endtask

  task automatic test_back_to_back();
    Instr = 16'h01B2; Instr_valid = 1'b1;
    tick();
    checks++; if ({ctl1, Imm_s, ALUOpCode, RdestRegLoc, RsrcRegLoc} !== {7'b0000011, 1'b0, 12'h212}) begin failures++; $display("FAIL cmp_exec got=%h exp=%h", {ctl1, Imm_s, ALUOpCode, RdestRegLoc, RsrcRegLoc}, {7'b0000011, 1'b0, 12'h212}); end
    Instr = 16'h7000;
    tick();
    checks++; if (ctl1 !== 7'b0010000) begin failures++; $display("FAIL cmp_pcupd got=%b exp=%b", ctl1, 7'b0010000); end
    tick();
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL b2b_fetch got=%b exp=0", Busy); end
    tick();
    Instr_valid = 1'b0;
    checks++; if ({ctl1, Busy, ALUOpCode} !== {7'b0000011, 1'b1, 4'd0}) begin failures++; $display("FAIL nop_exec got=%b exp=%b", {ctl1, Busy, ALUOpCode}, {7'b0000011, 1'b1, 4'd0}); end
    tick();
    checks++; if (ctl1 !== 7'b0010000) begin failures++; $display("FAIL nop_pcupd got=%b exp=%b", ctl1, 7'b0010000); end
    tick();
  endtask

  task automatic test_stor_fixed();
    logic [6:0] exp_seq [5] = '{7'b0100011, 7'b0000011, 7'b0000011, 7'b0010000, 7'b0000011};
    int ram_pulses = 0;
    int pc_pulses = 0;
    Instr = 16'h4142; valid2 = 1'b1; Mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        valid2 = 1'b0;
        checks++; if ({RamAddrSelect2, RdestRegLoc2, RsrcRegLoc2} !== 9'h112) begin failures++; $display("FAIL stor_exec_addr got=%h exp=112", {RamAddrSelect2, RdestRegLoc2, RsrcRegLoc2}); end
      end
      ram_pulses += int'(RAMEn2);
      pc_pulses += int'(PCEn2);
      checks++; if (ctl2 !== exp_seq[i]) begin failures++; $display("FAIL stor_seq%0d got=%b exp=%b", i, ctl2, exp_seq[i]); end
    end
    Mem_ready = 1'b0;
    checks++; if (ram_pulses != 1) begin failures++; $display("FAIL stor_ramen_count got=%0d exp=1", ram_pulses); end
    checks++; if (pc_pulses != 1) begin failures++; $display("FAIL stor_pcen_count got=%0d exp=1", pc_pulses); end
    checks++; if (Busy2 !== 1'b0) begin failures++; $display("FAIL stor_busy_end got=%b exp=0", Busy2); end
  endtask

  task automatic test_reset_mid_load();
    Instr = 16'h4205; Instr_valid = 1'b1; Mem_ready = 1'b0;
    tick();
    Instr_valid = 1'b0;
    tick();
    tick();
    checks++; if ({Busy, RamAddrSelect} !== 2'b11) begin failures++; $display("FAIL midload_memwait got=%b exp=11", {Busy, RamAddrSelect}); end
    Reset_n = 1'b0;
    #1;
    checks++; if ({ctl1, Busy, RamAddrSelect} !== 9'b000001100) begin failures++; $display("FAIL midload_abort got=%b exp=%b", {ctl1, Busy, RamAddrSelect}, 9'b000001100); end
    Mem_ready = 1'b1;
    tick();
    Reset_n = 1'b1;
    tick();
    Mem_ready = 1'b0;
    checks++; if ({ctl1, Busy} !== 8'b00000110) begin failures++; $display("FAIL midload_no_leak got=%b exp=%b", {ctl1, Busy}, 8'b00000110); end
    Instr = 16'h53FE; Instr_valid = 1'b1;
    tick();
    Instr_valid = 1'b0;
    checks++; if ({ctl1, Imm} !== {7'b1000011, 8'hFE}) begin failures++; $display("FAIL midload_resume got=%h exp=%h", {ctl1, Imm}, {7'b1000011, 8'hFE}); end
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_imm();
    test_load_handshake();
    test_branch();
    test_jump();
    test_back_to_back();
    test_stor_fixed();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
